// File: rtl/note_tone_gen_pkg.sv
// Shared definitions for the note tone generator.
//   SILENT       : half-period word meaning "channel not sounding"
//   NOTE_PERIOD  : 128-entry half-period table, entry 0 is SILENT
//   lookup_state_t : command lookup FSM states
package note_tone_gen_pkg;

    localparam int unsigned TABLE_W     = 16;
    localparam int unsigned TABLE_DEPTH = 128;
    localparam int unsigned TABLE_AW    = 7;

    localparam logic [TABLE_W-1:0] SILENT = '1;

    typedef logic [TABLE_W-1:0] period_table_t [TABLE_DEPTH];

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LOAD
    } lookup_state_t;

    // Half-periods of the lowest octave (notes 1..12); each higher octave
    // halves them with round-to-nearest.
    localparam logic [TABLE_W-1:0] OCTAVE_BASE [12] = '{
        16'd5772, 16'd5448, 16'd5142, 16'd4854, 16'd4581, 16'd4324,
        16'd4081, 16'd3852, 16'd3636, 16'd3432, 16'd3239, 16'd3058
    };

    function automatic period_table_t build_note_period();
        period_table_t t;
        int unsigned   semi;
        int unsigned   oct;
        int unsigned   base;
        for (int unsigned n = 0; n < TABLE_DEPTH; n++) begin
            semi = (n == 0) ? 0 : (n - 1) % 12;
            oct  = (n == 0) ? 0 : (n - 1) / 12;
            base = 32'(OCTAVE_BASE[semi[3:0]]);
            if (n == 0)
                t[n[TABLE_AW-1:0]] = SILENT;
            else if (oct == 0)
                t[n[TABLE_AW-1:0]] = TABLE_W'(base);
            else
                t[n[TABLE_AW-1:0]] = TABLE_W'((base + (32'd1 << (oct - 1))) >> oct);
        end
        return t;
    endfunction

    localparam period_table_t NOTE_PERIOD = build_note_period();

endpackage

// File: rtl/note_tone_gen_period_rom.sv
// Synchronous-read note half-period ROM.
//   clk  : clock
//   ce   : read enable; dout updates only when high
//   addr : note index
//   dout : registered half-period word (1-cycle latency)
// Indices beyond the package table read as all-ones (silent).
module note_period_rom
    import note_tone_gen_pkg::*;
#(
    parameter int unsigned NOTE_W   = 7,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                ce,
    input  logic [NOTE_W-1:0]   addr,
    output logic [PERIOD_W-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** NOTE_W;

    typedef logic [PERIOD_W-1:0] rom_t [DEPTH];

    function automatic rom_t build_rom();
        rom_t r;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == 0 || i >= TABLE_DEPTH)
                r[i[NOTE_W-1:0]] = '1;
            else
                r[i[NOTE_W-1:0]] = PERIOD_W'(NOTE_PERIOD[i[TABLE_AW-1:0]]);
        end
        return r;
    endfunction

    localparam rom_t ROM = build_rom();

    // No reset on dout so the array maps onto block ROM.
    always_ff @(posedge clk) begin
        if (ce)
            dout <= ROM[addr];
    end

endmodule

// File: rtl/note_tone_gen.sv
// Multi-channel square-wave note generator.
//   clk, reset_n  : clock, asynchronous active-low reset
//   note_valid    : command present; accepted when note_ready is high
//   note_ready    : lookup FSM idle
//   note_ch       : target channel (values >= CHANNELS are ignored)
//   note_idx      : note index into the half-period table
//   note_on       : 1 = play note_idx, 0 = silence the channel
//   tone          : square wave per channel
//   mix           : number of tone bits currently high
module note_tone_gen
    import note_tone_gen_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned NOTE_W   = 7,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           note_valid,
    output logic                           note_ready,
    input  logic [2:0]                     note_ch,
    input  logic [NOTE_W-1:0]              note_idx,
    input  logic                           note_on,
    output logic [CHANNELS-1:0]            tone,
    output logic [$clog2(CHANNELS+1)-1:0]  mix
);

    localparam int unsigned MIX_W = $clog2(CHANNELS + 1);
    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PERIOD_W-1:0] SILENT_P = '1;

    lookup_state_t state, state_nxt;

    logic [2:0]          cmd_ch;
    logic [NOTE_W-1:0]   cmd_idx;
    logic                cmd_on;
    logic                accept;
    logic                rom_ce;
    logic                load;
    logic [NOTE_W-1:0]   rom_addr;
    logic [PERIOD_W-1:0] rom_dout;
    logic [PS_W-1:0]     ps_cnt;
    logic                tick;

    // Lookup FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        note_ready = 1'b0;
        rom_ce     = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                note_ready = 1'b1;
                if (note_valid)
                    state_nxt = READ;
            end
            READ: begin
                rom_ce    = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                load      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = note_valid && note_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ch  <= '0;
            cmd_idx <= '0;
            cmd_on  <= 1'b0;
        end else if (accept) begin
            cmd_ch  <= note_ch;
            cmd_idx <= note_idx;
            cmd_on  <= note_on;
        end
    end

    // Entry 0 holds the silent word, so note-off simply reads address 0.
    assign rom_addr = cmd_on ? cmd_idx : '0;

    note_period_rom #(
        .NOTE_W   (NOTE_W),
        .PERIOD_W (PERIOD_W)
    ) u_rom (
        .clk  (clk),
        .ce   (rom_ce),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    // Prescaler
    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ps_cnt <= '0;
        else if (tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + 1'b1;
    end

    // Per-channel half-period counters
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] counter;
        logic                tone_q;
        logic                sel;

        assign sel = load && (cmd_ch == 3'(i));

        // A load takes priority over a coincident tick on this channel.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                period  <= SILENT_P;
                counter <= '0;
                tone_q  <= 1'b0;
            end else if (sel) begin
                period  <= rom_dout;
                counter <= rom_dout;
                tone_q  <= 1'b0;
            end else if (tick && period != SILENT_P) begin
                if (counter == '0) begin
                    counter <= period;
                    tone_q  <= ~tone_q;
                end else begin
                    counter <= counter - 1'b1;
                end
            end
        end

        assign tone[i] = tone_q;
    end

    always_comb begin
        mix = '0;
        for (int unsigned i = 0; i < CHANNELS; i++)
            mix = mix + MIX_W'(tone[i]);
    end

endmodule
